// File: rtl/sad_window_buffer.sv
// sad_window_buffer: two 32x32 buffer banks with pipeline stores and a
// stream-fed burst fill engine (indexed or shift-in). Option: BUF_FWD_EN.
module sad_window_buffer #(
    parameter int DEPTH = 32,
    parameter int AW    = 5,
    parameter int DW    = 32
) (
    input  logic          Clk,
    input  logic          Rst_n,
    input  logic [AW-1:0] buf_val_1_addr,
    input  logic [AW-1:0] buf_val_2_addr,
    output logic [DW-1:0] buf_val_1_select,
    output logic [DW-1:0] buf_val_2_select,
    input  logic          wr_en,
    input  logic          wr_sel,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          fill_start,
    input  logic          fill_sel,
    input  logic          fill_shift,
    input  logic [AW-1:0] fill_base,
    input  logic [AW:0]   fill_count,
    input  logic          s_valid,
    input  logic [DW-1:0] s_data,
    output logic          s_ready,
    output logic          busy,
    output logic          fill_done,
    output logic          wr_drop
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_FILL,
        S_DONE
    } state_t;

    localparam logic [AW:0]   LP_DEPTH = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] LP_TOP   = AW'(DEPTH-1);

    state_t        r_state;
    state_t        w_state_nxt;
    logic          r_s_ready;
    logic          w_s_ready_nxt;
    logic          r_sel;
    logic          r_shift;
    logic [AW-1:0] r_base;
    logic [AW:0]   r_count;
    logic [AW:0]   r_idx;
    logic [DW-1:0] r_bank_a [DEPTH];
    logic [DW-1:0] r_bank_b [DEPTH];

    logic [AW:0]   w_count_clamp;
    logic          w_acc;
    logic          w_last;
    logic          w_acc_a;
    logic          w_acc_b;
    logic          w_pwe_a;
    logic          w_pwe_b;
    logic [AW-1:0] w_fill_addr;

    assign w_count_clamp = (fill_count > LP_DEPTH) ? LP_DEPTH : fill_count;
    assign w_acc         = (r_state == S_FILL) && r_s_ready && s_valid;
    assign w_last        = (r_idx == r_count - 1'b1);
    assign w_acc_a       = w_acc && !r_sel;
    assign w_acc_b       = w_acc && r_sel;
    // A stream word landing in a bank pre-empts any store to that bank.
    assign w_pwe_a       = wr_en && !wr_sel && !w_acc_a;
    assign w_pwe_b       = wr_en && wr_sel && !w_acc_b;
    assign w_fill_addr   = r_base + r_idx[AW-1:0];

    assign s_ready   = r_s_ready;
    assign busy      = (r_state != S_IDLE);
    assign fill_done = (r_state == S_DONE);
    assign wr_drop   = wr_en && w_acc && (wr_sel == r_sel);

    // Next-state and registered-ready selection for the fill engine.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (fill_start) begin
                    w_state_nxt = (w_count_clamp == '0) ? S_DONE : S_FILL;
                end
            end
            S_FILL: begin
                if (w_acc && w_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
        w_s_ready_nxt = (w_state_nxt == S_FILL);
    end

    // State, ready flop, latched fill parameters and word index.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_state   <= S_IDLE;
            r_s_ready <= 1'b0;
            r_sel     <= 1'b0;
            r_shift   <= 1'b0;
            r_base    <= '0;
            r_count   <= '0;
            r_idx     <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_s_ready <= w_s_ready_nxt;
            if ((r_state == S_IDLE) && fill_start) begin
                r_sel   <= fill_sel;
                r_shift <= fill_shift;
                r_base  <= fill_base;
                r_count <= w_count_clamp;
                r_idx   <= '0;
            end else if (w_acc) begin
                r_idx <= r_idx + 1'b1;
            end
        end
    end

    // Bank A storage: stream fill has priority over pipeline stores.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_bank_a[i] <= '0;
            end
        end else if (w_acc_a) begin
            if (r_shift) begin
                for (int i = 0; i < DEPTH-1; i++) begin
                    r_bank_a[i] <= r_bank_a[i+1];
                end
                r_bank_a[DEPTH-1] <= s_data;
            end else begin
                r_bank_a[w_fill_addr] <= s_data;
            end
        end else if (w_pwe_a) begin
            r_bank_a[wr_addr] <= wr_data;
        end
    end

    // Bank B storage: stream fill has priority over pipeline stores.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_bank_b[i] <= '0;
            end
        end else if (w_acc_b) begin
            if (r_shift) begin
                for (int i = 0; i < DEPTH-1; i++) begin
                    r_bank_b[i] <= r_bank_b[i+1];
                end
                r_bank_b[DEPTH-1] <= s_data;
            end else begin
                r_bank_b[w_fill_addr] <= s_data;
            end
        end else if (w_pwe_b) begin
            r_bank_b[wr_addr] <= wr_data;
        end
    end

`ifdef BUF_FWD_EN
    // Port A read with write-through of whatever lands this cycle.
    always_comb begin
        buf_val_1_select = r_bank_a[buf_val_1_addr];
        if (w_acc_a) begin
            if (r_shift) begin
                if (buf_val_1_addr == LP_TOP) begin
                    buf_val_1_select = s_data;
                end else begin
                    buf_val_1_select = r_bank_a[AW'(buf_val_1_addr + 1'b1)];
                end
            end else if (buf_val_1_addr == w_fill_addr) begin
                buf_val_1_select = s_data;
            end
        end else if (w_pwe_a && (wr_addr == buf_val_1_addr)) begin
            buf_val_1_select = wr_data;
        end
    end

    // Port B read with write-through of whatever lands this cycle.
    always_comb begin
        buf_val_2_select = r_bank_b[buf_val_2_addr];
        if (w_acc_b) begin
            if (r_shift) begin
                if (buf_val_2_addr == LP_TOP) begin
                    buf_val_2_select = s_data;
                end else begin
                    buf_val_2_select = r_bank_b[AW'(buf_val_2_addr + 1'b1)];
                end
            end else if (buf_val_2_addr == w_fill_addr) begin
                buf_val_2_select = s_data;
            end
        end else if (w_pwe_b && (wr_addr == buf_val_2_addr)) begin
            buf_val_2_select = wr_data;
        end
    end
`else
    assign buf_val_1_select = r_bank_a[buf_val_1_addr];
    assign buf_val_2_select = r_bank_b[buf_val_2_addr];
`endif

endmodule
